mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive cycles one owner keeps the mux while others wait (legal 1..15).
REQ-002 Port: Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  8  request per requester; bit i = requester i wants mux input W[i]; held high while access is needed.
REQ-005 Port: grant  output  8  one-hot grant; bit i = requester i owns the mux; all-zero when idle.
REQ-006 Port: S  output  4  select driven straight into the 8:1 mux; values 0..7 only; bit 3 always 0.
REQ-007 Port: valid  output  1  high when the mux output belongs to a granted requester.

Function
REQ-008 The block SHALL be a two-state FSM: IDLE (no owner) and BUSY (one owner), all outputs registered.
REQ-009 Arbitration SHALL be round-robin: the winner is the first asserted req bit at or above pointer ptr, wrapping 7->0.
REQ-010 ptr SHALL become (winner+1) mod 8 on every new grant; on BUSY->IDLE it SHALL be unchanged.
REQ-011 IDLE with req != 0 SHALL move to BUSY next edge; grant, S=winner and valid=1 appear one cycle after req is sampled.
REQ-012 IDLE with req == 0 SHALL stay IDLE; grant=0, valid=0, S holds its last value.
REQ-013 In BUSY the owner SHALL keep the grant while req[owner]=1 and hold_cnt < HOLD_MAX-1, or while no other req bit is set.
REQ-014 hold_cnt SHALL clear to 0 on every new grant, increment each BUSY cycle, and saturate at HOLD_MAX-1.
REQ-015 When req[owner]=0, or hold_cnt = HOLD_MAX-1 with another req pending, the arbiter SHALL hand over next edge to the round-robin winner among the other requesters, with no idle bubble.
REQ-016 When req[owner]=0 and no other req is set, the FSM SHALL return to IDLE next edge.
REQ-017 The preempted owner's still-asserted req SHALL be excluded from the handover pick and compete normally from the following cycle.
REQ-018 A req bit that rises in the same cycle as a handover SHALL be included in that pick.
REQ-019 grant SHALL always be one-hot or zero, and valid SHALL equal |grant.
REQ-020 S SHALL always equal the index of the set grant bit whenever valid=1.

Reset
REQ-021 Reset SHALL set state=IDLE, grant=0, S=0, valid=0, ptr=0, hold_cnt=0 on the next edge.
REQ-022 Reset SHALL override all other activity, including a BUSY cycle or a handover in progress.
REQ-023 The first grant after reset SHALL follow priority from requester 0.

Structure
REQ-024 A shared header SHALL define N_REQ=8, SEL_W=4, the state encodings IDLE=0 and BUSY=1, and the default HOLD_MAX.
REQ-025 The rotating pick SHALL be a combinational sub-module rr_pick8 (inputs: 8-bit request mask, 3-bit ptr; outputs: 3-bit index, found flag), instanced once.
REQ-026 S SHALL connect directly to the existing 8:1 mux select, with no glue logic.

Verification
REQ-027 Reset, then req=8'h00 for 5 cycles -> grant=0, valid=0, S=0 throughout.
REQ-028 req=8'h24 from reset -> next cycle grant=8'h04, S=2; drop req[2] -> next cycle grant=8'h20, S=5, no idle cycle.
REQ-029 req=8'hFF held, HOLD_MAX=8 -> owners rotate 0,1,...,7,0 with exactly 8 cycles each.
REQ-030 req=8'h01 alone held for 20 cycles -> grant=8'h01 for all 20 cycles, no preemption; drop req -> IDLE next cycle.
REQ-031 Owner 6 BUSY, req=8'h41, Reset asserted for 1 cycle -> next cycle grant=0, S=0, valid=0; following cycle grant=8'h01.
REQ-032 Random req for 10k cycles -> onehot0(grant), valid==|grant, S==index(grant), and no requester waits more than 7*HOLD_MAX+1 cycles.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

    localparam int N_REQ        = 8;
    localparam int SEL_W        = 4;
    localparam int IDX_W        = 3;
    localparam int HOLD_MAX_DEF = 8;
    localparam int HOLD_W       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick8.sv
// Rotating-priority pick: first set mask bit at or above ptr, wrapping 7->0.
module rr_pick8
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (mask[cand]) begin
                index = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for an 8:1 mux with bounded hold time per owner.
//
// state | meaning
// IDLE  | no owner, grant=0, valid=0, S holds last select
// BUSY  | one owner, grant one-hot, S = owner index
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] S,
    output logic             valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [N_REQ-1:0]  others;
    logic [IDX_W-1:0]  pick;
    logic              pick_found;
    logic              owner_req;
    logic              keep;

    // grant is zero in IDLE, so one mask serves both the idle pick and the
    // handover pick that must skip the current owner.
    assign others    = req & ~grant;
    assign owner_req = |(req & grant);
    assign keep      = owner_req && ((hold_cnt < HOLD_LAST) || (others == '0));

    rr_pick8 u_pick (
        .mask  (others),
        .ptr   (ptr),
        .index (pick),
        .found (pick_found)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            S        <= '0;
            valid    <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= BUSY;
                        grant    <= idx_to_onehot(pick);
                        S        <= {1'b0, pick};
                        valid    <= 1'b1;
                        ptr      <= pick + IDX_W'(1);
                        hold_cnt <= '0;
                    end else begin
                        grant <= '0;
                        valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (keep) begin
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end else if (pick_found) begin
                        grant    <= idx_to_onehot(pick);
                        S        <= {1'b0, pick};
                        valid    <= 1'b1;
                        ptr      <= pick + IDX_W'(1);
                        hold_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized checks of the round-robin mux arbiter.
module tb_mux_rr_arbiter;

    logic       clk_sys;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [3:0] S;
    logic       valid;

    int total;
    int bad;

    mux_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .S       (S),
        .valid   (valid)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        tick();
        total++;
        if (grant !== 8'h00 || S !== 4'd0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL reset: grant=%h S=%0d valid=%b, want grant=00 S=0 valid=0", grant, S, valid);
        end
        rst = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_idle();
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (grant !== 8'h00 || S !== 4'd0 || valid !== 1'b0) begin
                bad++;
                $display("FAIL idle cyc%0d: grant=%h S=%0d valid=%b, want 00/0/0", c, grant, S, valid);
            end
        end
    endtask

    task automatic test_handover();
        apply_reset();
        req = 8'h24;
        tick();
        total++;
        if (grant !== 8'h04 || S !== 4'd2 || valid !== 1'b1) begin
            bad++;
            $display("FAIL handover_first: grant=%h S=%0d valid=%b, want 04/2/1", grant, S, valid);
        end
        req = 8'h20;
        tick();
        total++;
        if (grant !== 8'h20 || S !== 4'd5 || valid !== 1'b1) begin
            bad++;
            $display("FAIL handover_next: grant=%h S=%0d valid=%b, want 20/5/1", grant, S, valid);
        end
        req = 8'h00;
        tick();
        total++;
        if (grant !== 8'h00 || S !== 4'd5 || valid !== 1'b0) begin
            bad++;
            $display("FAIL handover_idle: grant=%h S=%0d valid=%b, want 00/5/0", grant, S, valid);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g;
        apply_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            for (int c = 0; c < 8; c++) begin
                tick();
                total++;
                if (grant !== exp_g || S !== 4'(k % 8) || valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rotation owner%0d cyc%0d: grant=%h S=%0d, want %h/%0d", k % 8, c, grant, S, exp_g, k % 8);
                end
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_single_hold();
        apply_reset();
        req = 8'h01;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (grant !== 8'h01 || S !== 4'd0 || valid !== 1'b1) begin
                bad++;
                $display("FAIL single cyc%0d: grant=%h S=%0d valid=%b, want 01/0/1", c, grant, S, valid);
            end
        end
        req = 8'h00;
        tick();
        total++;
        if (grant !== 8'h00 || valid !== 1'b0) begin
            bad++;
            $display("FAIL single_release: grant=%h valid=%b, want 00/0", grant, valid);
        end
    endtask

    task automatic test_reset_busy();
        apply_reset();
        req = 8'h40;
        tick();
        total++;
        if (grant !== 8'h40 || S !== 4'd6) begin
            bad++;
            $display("FAIL rstbusy_owner: grant=%h S=%0d, want 40/6", grant, S);
        end
        req = 8'h41;
        rst = 1'b1;
        tick();
        total++;
        if (grant !== 8'h00 || S !== 4'd0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL rstbusy_reset: grant=%h S=%0d valid=%b, want 00/0/0", grant, S, valid);
        end
        rst = 1'b0;
        tick();
        total++;
        if (grant !== 8'h01 || S !== 4'd0 || valid !== 1'b1) begin
            bad++;
            $display("FAIL rstbusy_after: grant=%h S=%0d valid=%b, want 01/0/1", grant, S, valid);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_same_cycle_rise();
        apply_reset();
        req = 8'h01;
        tick();
        req = 8'h10;
        tick();
        total++;
        if (grant !== 8'h10 || S !== 4'd4 || valid !== 1'b1) begin
            bad++;
            $display("FAIL rise_pick: grant=%h S=%0d valid=%b, want 10/4/1", grant, S, valid);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_ptr_kept();
        // After owner 2 leaves, ptr stays at 3: from 3 the pick among {2,4} is 4.
        apply_reset();
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        tick();
        req = 8'h14;
        tick();
        total++;
        if (grant !== 8'h10 || S !== 4'd4) begin
            bad++;
            $display("FAIL ptr_kept: grant=%h S=%0d, want 10/4", grant, S);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_preempt_exclude();
        // Owner 0 saturates with 1 and 7 pending; ptr=1 so 1 wins, 0 excluded.
        apply_reset();
        req = 8'h83;
        for (int c = 0; c < 8; c++) tick();
        total++;
        if (grant !== 8'h01) begin
            bad++;
            $display("FAIL preempt_hold: grant=%h, want 01", grant);
        end
        tick();
        total++;
        if (grant !== 8'h02 || S !== 4'd1) begin
            bad++;
            $display("FAIL preempt_next: grant=%h S=%0d, want 02/1", grant, S);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_random();
        int wait_cnt [8];
        int gidx;
        apply_reset();
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            tick();
            gidx = 0;
            for (int i = 0; i < 8; i++) if (grant[i]) gidx = i;
            total++;
            if (!$onehot0(grant) || valid !== (|grant) || S[3] !== 1'b0 ||
                (valid && S !== 4'(gidx))) begin
                bad++;
                $display("FAIL random_inv cyc%0d: grant=%h S=%0d valid=%b", c, grant, S, valid);
            end
            for (int i = 0; i < 8; i++) begin
                if (req[i] && !grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > 7 * 8 + 1) begin
                    total++;
                    bad++;
                    $display("FAIL random_wait req%0d: waited=%0d, limit=%0d", i, wait_cnt[i], 7 * 8 + 1);
                    wait_cnt[i] = 0;
                end
            end
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 8'h00;
        @(negedge clk_sys);
        test_reset();
        test_idle();
        test_handover();
        test_rotation();
        test_single_hold();
        test_reset_busy();
        test_same_cycle_rise();
        test_ptr_kept();
        test_preempt_exclude();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
